// File: rtl/pkt_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : pkt_mux_rr
// Purpose  : N-input packet-aware flit multiplexer. Arbitrates HEAD flits
//            (round-robin or external select), locks the grant until TAIL,
//            and drives a registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_mux_rr #(
  parameter int N     = 4,
  parameter int DATAW = 64,
  parameter int TYPEW = 2,
  parameter int VCHW  = 2,
  parameter int MODE  = 0,
  parameter int SELW  = 4
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [N*(TYPEW+DATAW)-1:0]    idata,
  input  logic [N-1:0]                  ivalid,
  input  logic [N*VCHW-1:0]             ivch,
  output logic [N-1:0]                  iready,
  input  logic [SELW-1:0]               sel,
  output logic [TYPEW+DATAW-1:0]        odata,
  output logic                          ovalid,
  output logic [VCHW-1:0]               ovch,
  input  logic                          oready,
  output logic [SELW-1:0]               grant,
  output logic                          locked,
  output logic                          err,
  output logic [15:0]                   pkt_cnt
);

  localparam int         c_FLITW = TYPEW + DATAW;
  localparam logic [1:0] c_HEAD  = 2'b01;
  localparam logic [1:0] c_TAIL  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SELW-1:0]        r_ptr;
  logic [SELW-1:0]        r_grant;
  logic                   r_err;
  logic [15:0]            r_pkt_cnt;
  logic [c_FLITW-1:0]     r_odata;
  logic                   r_ovalid;
  logic [VCHW-1:0]        r_ovch;

  logic [c_FLITW-1:0]     w_flit [N];
  logic [VCHW-1:0]        w_vch  [N];
  logic [N-1:0]           w_cand;
  logic                   w_found;
  logic [SELW-1:0]        w_win;
  int                     w_idx;
  logic [SELW-1:0]        w_src;
  logic [c_FLITW-1:0]     w_sel_flit;
  logic [VCHW-1:0]        w_sel_vch;
  logic [1:0]             w_sel_type;
  logic                   w_load_ok;
  logic [N-1:0]           w_iready;
  logic                   w_xfer;

  // Unpack the per-port buses; a port is a HEAD candidate only when valid,
  // carrying HEAD and (in select mode) addressed by sel.
  generate
    for (genvar k = 0; k < N; k++) begin : g_port
      assign w_flit[k] = idata[k*c_FLITW +: c_FLITW];
      assign w_vch[k]  = ivch[k*VCHW +: VCHW];
      assign w_cand[k] = ivalid[k] && (w_flit[k][c_FLITW-1 -: 2] == c_HEAD) &&
                         ((MODE == 0) || (sel == SELW'(k)));
    end
  endgenerate

  assign w_load_ok = !r_ovalid || oready;

  // Winner search: first candidate at or after ptr, wrapping. In select mode
  // ptr stays zero and at most one candidate exists, so the same search works.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = SELW'(w_idx);
      end
    end
  end

  assign w_src = (r_state == S_IDLE) ? w_win : r_grant;

  // Source flit mux plus per-port accept; accepts are forced low during reset.
  always_comb begin
    w_sel_flit = '0;
    w_sel_vch  = '0;
    w_iready   = '0;
    for (int k = 0; k < N; k++) begin
      if (w_src == SELW'(k)) begin
        w_sel_flit = w_flit[k];
        w_sel_vch  = w_vch[k];
      end
      if (r_state == S_IDLE)
        w_iready[k] = rst_ && w_load_ok && w_found && (w_win == SELW'(k));
      else
        w_iready[k] = rst_ && w_load_ok && (r_grant == SELW'(k));
    end
  end

  assign w_sel_type = w_sel_flit[c_FLITW-1 -: 2];
  assign w_xfer     = |(ivalid & w_iready);

  // Packet-lock FSM with the registered output stage and status counters.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_err     <= 1'b0;
      r_pkt_cnt <= '0;
      r_odata   <= '0;
      r_ovalid  <= 1'b0;
      r_ovch    <= '0;
    end else begin
      if (w_xfer) begin
        r_odata  <= w_sel_flit;
        r_ovch   <= w_sel_vch;
        r_ovalid <= 1'b1;
      end else if (oready) begin
        r_ovalid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_grant <= w_win;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            if (w_sel_type == c_TAIL) begin
              r_state   <= S_IDLE;
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
              if (MODE == 0)
                r_ptr <= (r_grant >= SELW'(N-1)) ? '0 : r_grant + 1'b1;
            end else if (!w_sel_type[1]) begin
              // HEAD or NONE inside a packet: forwarded, but flagged.
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign iready  = w_iready;
  assign odata   = r_odata;
  assign ovalid  = r_ovalid;
  assign ovch    = r_ovch;
  assign grant   = r_grant;
  assign locked  = (r_state == S_LOCKED);
  assign err     = r_err;
  assign pkt_cnt = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pkt_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_mux_rr
// Purpose  : Directed self-checking bench for pkt_mux_rr. One instance in
//            round-robin mode, one in select mode, sharing the input stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_mux_rr;

  localparam int FW = 66;

  logic            clk;
  logic            rst_;
  logic [4*FW-1:0] idata;
  logic [3:0]      ivalid;
  logic [7:0]      ivch;
  logic [3:0]      sel;
  logic            oready;

  logic [3:0]      o0_iready, o1_iready;
  logic [FW-1:0]   o0_odata,  o1_odata;
  logic            o0_ovalid, o1_ovalid;
  logic [1:0]      o0_ovch,   o1_ovch;
  logic [3:0]      o0_grant,  o1_grant;
  logic            o0_locked, o1_locked;
  logic            o0_err,    o1_err;
  logic [15:0]     o0_pkt,    o1_pkt;

  int              total;
  int              bad;
  int              pos [4];
  logic [3:0]      acc;
  int              q;
  int              r;
  logic            prev_hold;
  logic [FW-1:0]   prev_od;

  pkt_mux_rr #(.N(4), .DATAW(64), .TYPEW(2), .VCHW(2), .MODE(0), .SELW(4)) dut0 (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .iready(o0_iready), .sel(sel), .odata(o0_odata), .ovalid(o0_ovalid),
    .ovch(o0_ovch), .oready(oready), .grant(o0_grant), .locked(o0_locked),
    .err(o0_err), .pkt_cnt(o0_pkt)
  );

  pkt_mux_rr #(.N(4), .DATAW(64), .TYPEW(2), .VCHW(2), .MODE(1), .SELW(4)) dut1 (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .iready(o1_iready), .sel(sel), .odata(o1_odata), .ovalid(o1_ovalid),
    .ovch(o1_ovch), .oready(oready), .grant(o1_grant), .locked(o1_locked),
    .err(o1_err), .pkt_cnt(o1_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [63:0] d);
    return {t, d};
  endfunction

  task automatic put(input int k, input logic [FW-1:0] f);
    idata[k*FW +: FW] = f;
    ivch[k*2 +: 2]    = 2'(k);
  endtask

  // Fairness packets: 4 flits each; n counts flits a port has sent in total.
  function automatic logic [FW-1:0] fflit(input int k, input int n);
    int i;
    int p;
    logic [1:0] t;
    i = n % 4;
    p = n / 4;
    t = (i == 0) ? 2'b01 : ((i == 3) ? 2'b11 : 2'b10);
    return mk(t, 64'(k*256 + p*16 + i));
  endfunction

  function automatic logic [FW-1:0] bpflit(input int n);
    logic [1:0] t;
    t = (n == 0) ? 2'b01 : ((n == 21) ? 2'b11 : 2'b10);
    return mk(t, 64'(32'h2000 + n));
  endfunction

  initial begin
    total  = 0;
    bad    = 0;
    idata  = '0;
    ivch   = '0;
    ivalid = '0;
    sel    = 4'd15;
    oready = 1'b1;
    rst_   = 1'b0;
    for (int k = 0; k < 4; k++) pos[k] = 0;

    // ---- reset state, with a HEAD already offered ----
    put(0, mk(2'b01, 64'h0));
    ivalid = 4'b0001;
    #2;
    chk("rst_iready", o0_iready, 4'b0000);
    chk("rst_ovalid", o0_ovalid, 1'b0);
    chk("rst_odata",  o0_odata,  '0);
    chk("rst_grant",  o0_grant,  4'd0);
    chk("rst_locked", o0_locked, 1'b0);
    chk("rst_err",    o0_err,    1'b0);
    chk("rst_pkt",    o0_pkt,    16'd0);
    tick();
    tick();
    rst_ = 1'b1;

    // ---- fairness: all ports stream 4-flit packets ----
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < 4; k++) put(k, fflit(k, pos[k]));
      ivalid = 4'hF;
      oready = 1'b1;
      #1;
      acc = ivalid & o0_iready;
      chk("fair_accept", acc, 4'b0001 << ((c / 4) % 4));
      if (c > 0) begin
        chk("fair_odata", o0_odata, fflit(((c-1)/4) % 4, ((c-1)/16)*4 + (c-1) % 4));
        chk("fair_ovalid", o0_ovalid, 1'b1);
      end
      tick();
      for (int k = 0; k < 4; k++) if (acc[k]) pos[k]++;
    end
    ivalid = 4'b0000;
    #1;
    chk("fair_last", o0_odata, fflit(0, 7));
    chk("fair_ovch", o0_ovch, 2'd0);
    chk("fair_pkt", o0_pkt, 16'd5);
    chk("fair_unlocked", o0_locked, 1'b0);
    tick();
    chk("fair_drain", o0_ovalid, 1'b0);

    // ---- backpressure: port 2, 22-flit packet, oready 1,0,0,1 ----
    q = 0;
    r = 0;
    prev_hold = 1'b0;
    prev_od = '0;
    for (int c = 0; c < 120 && r < 22; c++) begin
      oready = ((c % 4) == 0) || ((c % 4) == 3);
      if (q < 22) begin
        put(2, bpflit(q));
        ivalid = 4'b0100;
      end else begin
        ivalid = 4'b0000;
      end
      #1;
      if (prev_hold) chk("bp_hold", o0_odata, prev_od);
      if (o0_ovalid && !oready) chk("bp_stall_iready", o0_iready[2], 1'b0);
      if (o0_ovalid && oready) begin
        chk("bp_order", o0_odata, bpflit(r));
        r++;
      end
      prev_hold = o0_ovalid && !oready;
      prev_od   = o0_odata;
      if (ivalid[2] && o0_iready[2]) q++;
      tick();
    end
    chk("bp_count", r, 22);
    chk("bp_pkt", o0_pkt, 16'd6);
    chk("bp_err", o0_err, 1'b0);
    oready = 1'b1;
    ivalid = 4'b0000;
    tick();

    // ---- locking: port 1 HEAD waits for port 0 TAIL ----
    put(0, mk(2'b01, 64'h100));
    ivalid = 4'b0001;
    #1;
    chk("lock_c0_iready", o0_iready, 4'b0001);
    tick();
    put(0, mk(2'b10, 64'h101));
    put(1, mk(2'b01, 64'h110));
    ivalid = 4'b0011;
    #1;
    chk("lock_c1_iready", o0_iready, 4'b0001);
    tick();
    chk("lock_c1_odata", o0_odata, mk(2'b10, 64'h101));
    put(0, mk(2'b11, 64'h102));
    #1;
    chk("lock_c2_iready", o0_iready, 4'b0001);
    tick();
    chk("lock_tail_out", o0_odata, mk(2'b11, 64'h102));
    chk("lock_tail_unlocked", o0_locked, 1'b0);
    ivalid = 4'b0010;
    #1;
    chk("lock_next_iready", o0_iready, 4'b0010);
    tick();
    chk("lock_next_odata", o0_odata, mk(2'b01, 64'h110));
    chk("lock_next_grant", o0_grant, 4'd1);
    chk("lock_next_ovch", o0_ovch, 2'd1);
    put(1, mk(2'b11, 64'h111));
    tick();
    ivalid = 4'b0000;
    chk("lock_pkt", o0_pkt, 16'd8);

    // ---- protocol error: HEAD, DATA, HEAD, TAIL from port 3 ----
    put(3, mk(2'b01, 64'h3000));
    ivalid = 4'b1000;
    #1;
    chk("perr_iready", o0_iready, 4'b1000);
    tick();
    chk("perr_grant", o0_grant, 4'd3);
    put(3, mk(2'b10, 64'h3001));
    tick();
    chk("perr_err_before", o0_err, 1'b0);
    put(3, mk(2'b01, 64'h3002));
    tick();
    chk("perr_err_set", o0_err, 1'b1);
    chk("perr_head2_out", o0_odata, mk(2'b01, 64'h3002));
    chk("perr_still_locked", o0_locked, 1'b1);
    put(3, mk(2'b11, 64'h3003));
    tick();
    chk("perr_tail_out", o0_odata, mk(2'b11, 64'h3003));
    chk("perr_pkt", o0_pkt, 16'd9);
    chk("perr_sticky", o0_err, 1'b1);

    // ---- reset mid-packet: port 3 HEAD+DATA, then async reset ----
    put(3, mk(2'b01, 64'h3010));
    tick();
    put(3, mk(2'b10, 64'h3011));
    tick();
    chk("mid_locked_before", o0_locked, 1'b1);
    rst_ = 1'b0;
    put(0, mk(2'b01, 64'h500));
    ivalid = 4'b0001;
    #1;
    chk("mid_rst_odata",  o0_odata,  '0);
    chk("mid_rst_ovalid", o0_ovalid, 1'b0);
    chk("mid_rst_ovch",   o0_ovch,   2'd0);
    chk("mid_rst_iready", o0_iready, 4'b0000);
    chk("mid_rst_grant",  o0_grant,  4'd0);
    chk("mid_rst_locked", o0_locked, 1'b0);
    chk("mid_rst_err",    o0_err,    1'b0);
    chk("mid_rst_pkt",    o0_pkt,    16'd0);
    tick();
    rst_ = 1'b1;
    #1;
    chk("mid_first_iready", o0_iready, 4'b0001);
    tick();
    chk("mid_first_odata", o0_odata, mk(2'b01, 64'h500));
    chk("mid_first_locked", o0_locked, 1'b1);
    put(0, mk(2'b11, 64'h501));
    tick();
    ivalid = 4'b0000;

    // ---- select mode (dut1) ----
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    sel = 4'd1;
    put(0, mk(2'b01, 64'h600));
    put(1, mk(2'b01, 64'h610));
    ivalid = 4'b0011;
    #1;
    chk("sel_iready", o1_iready, 4'b0010);
    tick();
    chk("sel_grant", o1_grant, 4'd1);
    chk("sel_odata", o1_odata, mk(2'b01, 64'h610));
    sel = 4'd0;
    put(1, mk(2'b10, 64'h611));
    #1;
    chk("sel_change_iready", o1_iready, 4'b0010);
    tick();
    chk("sel_change_grant", o1_grant, 4'd1);
    chk("sel_change_locked", o1_locked, 1'b1);
    put(1, mk(2'b11, 64'h612));
    tick();
    chk("sel_tail_odata", o1_odata, mk(2'b11, 64'h612));
    chk("sel_pkt", o1_pkt, 16'd1);
    chk("sel_unlocked", o1_locked, 1'b0);
    sel = 4'd5;
    for (int k = 0; k < 4; k++) put(k, mk(2'b01, 64'(32'h700 + k)));
    ivalid = 4'b1111;
    #1;
    chk("sel_oob_iready", o1_iready, 4'b0000);
    tick();
    chk("sel_oob_locked", o1_locked, 1'b0);
    chk("sel_oob_ovalid", o1_ovalid, 1'b0);
    ivalid = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
